rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arb_pkg.sv | 11 +
 rtl/rom_arb_rr.sv | 21 ++
 rtl/rom_arbiter.sv | 102 ++++++++++
 tb/tb_rom_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared definitions for the ROM read arbiter.
//   state_t  - arbiter FSM state encoding (IDLE=0, ISSUE=1, CAPTURE=2)
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/rom_arb_rr.sv
// rom_arb_rr: combinational 2-way round-robin choice.
//   req0, req1 : requests from requester 0/1
//   last       : index of the requester granted most recently
//   grant      : index of the chosen requester (meaningful when valid)
//   valid      : at least one request present
module rom_arb_rr (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    // On a tie the requester that was not served last wins.
    if (req0 && req1) grant = ~last;
    else              grant = req1;
  end

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one external single-port synchronous ROM between two
// requesters. Each read takes IDLE(grant) -> ISSUE -> CAPTURE.
//   clk, rstn        : clock, asynchronous active-low reset
//   req0/1, addr0/1  : level-sensitive read requests and their addresses
//   done0/1          : one-cycle pulse, rdata0/1 freshly valid
//   rdata0/1         : last data returned to each requester
//   rom_addr         : registered ROM address
//   rom_data         : ROM read data, valid one edge after rom_addr
//   busy             : FSM not in IDLE
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          busy
);

  state_t state, state_next;
  logic   last;       // most recently granted requester
  logic   gnt;        // requester owning the current transaction
  logic   rr_grant;
  logic   rr_valid;
  logic   load_grant;
  logic   capture;

  rom_arb_rr u_rr (
    .req0  (req0),
    .req1  (req1),
    .last  (last),
    .grant (rr_grant),
    .valid (rr_valid)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (rr_valid) state_next = ISSUE;
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    load_grant = (state == IDLE) && rr_valid;
    capture    = (state == CAPTURE);
    busy       = (state != IDLE);
  end

  // Datapath: address latch, grant bookkeeping, data return.
  // rom_addr only moves on a grant, so it holds through ISSUE/CAPTURE/IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last     <= 1'b1;
      gnt      <= 1'b0;
      rom_addr <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
      done0    <= 1'b0;
      done1    <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (load_grant) begin
        gnt      <= rr_grant;
        last     <= rr_grant;
        rom_addr <= rr_grant ? addr1 : addr0;
      end
      if (capture) begin
        if (gnt) begin
          rdata1 <= rom_data;
          done1  <= 1'b1;
        end else begin
          rdata0 <= rom_data;
          done0  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed self-checking bench for rom_arbiter with a
// behavioural synchronous ROM holding 0x800+addr (ROM[5] = 0xABC).
module tb_rom_arbiter;
  import rom_arb_pkg::*;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 12;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic          done0, done1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned d0_cnt   = 0;
  int unsigned d1_cnt   = 0;
  int unsigned snap0, snap1;
  logic [AW-1:0] held_addr;
  logic [1:0]    exp_d;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  rom_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req0     (req0),
    .req1     (req1),
    .addr0    (addr0),
    .addr1    (addr1),
    .done0    (done0),
    .done1    (done1),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 12'h800 + 12'(i);
    mem[5] = 12'hABC;
  end

  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Invariant monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      check("excl_done", 32'(done0 & done1), 32'd0);
      check("busy_state", 32'(busy), 32'(dut.state != IDLE));
      if (dut.state == ISSUE) held_addr = rom_addr;
      if (dut.state == CAPTURE) check("addr_stable", 32'(rom_addr), 32'(held_addr));
      if (done0 === 1'b1) d0_cnt++;
      if (done1 === 1'b1) d1_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    #2 rstn = 1'b0;
    tick(); tick();
    check("rst_done0", 32'(done0), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_rdata0", 32'(rdata0), 32'd0);
    check("rst_rdata1", 32'(rdata1), 32'd0);

    // Single read, first grant on the first edge after release (E0 -> E1).
    rstn = 1'b1; req0 = 1'b1; addr0 = 9'h005;
    tick();
    check("single_addr", 32'(rom_addr), 32'h005);
    check("single_busy", 32'(busy), 32'd1);
    tick();
    check("single_done_early", 32'(done0), 32'd0);
    tick();
    check("single_done0", 32'(done0), 32'd1);
    check("single_rdata0", 32'(rdata0), 32'hABC);
    check("single_busy_done", 32'(busy), 32'd0);
    req0 = 1'b0;
    tick();
    check("single_done_pulse", 32'(done0), 32'd0);
    tick();
    check("single_no_done1", 32'(d1_cnt), 32'd0);

    // Tie after reset: requester 0 first, then alternation every 3 cycles.
    rstn = 1'b0; #1 rstn = 1'b1;
    req0 = 1'b1; req1 = 1'b1; addr0 = 9'h010; addr1 = 9'h020;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k % 3 == 0) exp_d = (k % 6 == 3) ? 2'b10 : 2'b01;
      else            exp_d = 2'b00;
      check("tie_done", 32'({done0, done1}), 32'(exp_d));
      if (k % 3 == 1)
        check("tie_addr", 32'(rom_addr), (k % 6 == 1) ? 32'h010 : 32'h020);
      if (k == 3) begin
        check("tie_rdata0", 32'(rdata0), 32'h810);
        check("tie_rdata1_hold", 32'(rdata1), 32'd0);
      end
      if (k == 6) begin
        check("tie_rdata1", 32'(rdata1), 32'h820);
        check("tie_rdata0_hold", 32'(rdata0), 32'h810);
      end
    end
    req0 = 1'b0; req1 = 1'b0; addr0 = 9'h1FF; addr1 = 9'h1FE;
    tick(); tick(); tick();
    check("idle_addr_hold", 32'(rom_addr), 32'h020);
    check("idle_busy", 32'(busy), 32'd0);

    // Address change after the grant is ignored.
    req1 = 1'b1; addr1 = 9'h030;
    tick();
    check("chg_addr", 32'(rom_addr), 32'h030);
    addr1 = 9'h031; req1 = 1'b0;
    tick(); tick();
    check("chg_done1", 32'(done1), 32'd1);
    check("chg_rdata1", 32'(rdata1), 32'h830);
    check("chg_rdata0_hold", 32'(rdata0), 32'h810);

    // One-cycle request still completes exactly once.
    tick();
    snap0 = d0_cnt;
    req0 = 1'b1; addr0 = 9'h044;
    tick();
    req0 = 1'b0;
    tick(); tick();
    check("drop_done0", 32'(done0), 32'd1);
    check("drop_rdata0", 32'(rdata0), 32'h844);
    for (int k = 0; k < 5; k++) tick();
    check("drop_count", d0_cnt - snap0, 32'd1);
    check("drop_busy", 32'(busy), 32'd0);

    // Reset while in ISSUE discards the transaction.
    req0 = 1'b1; addr0 = 9'h055;
    tick();
    req0 = 1'b0;
    check("mid_issue_busy", 32'(busy), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addr", 32'(rom_addr), 32'd0);
    check("mid_rst_rdata0", 32'(rdata0), 32'd0);
    check("mid_rst_rdata1", 32'(rdata1), 32'd0);
    check("mid_rst_done0", 32'(done0), 32'd0);
    tick();
    rstn = 1'b1;
    snap0 = d0_cnt; snap1 = d1_cnt;
    for (int k = 0; k < 5; k++) tick();
    check("mid_no_done", (d0_cnt - snap0) + (d1_cnt - snap1), 32'd0);
    req0 = 1'b1; addr0 = 9'h066;
    tick();
    req0 = 1'b0;
    tick();
    check("post_rst_early", 32'(done0), 32'd0);
    tick();
    check("post_rst_done0", 32'(done0), 32'd1);
    check("post_rst_rdata0", 32'(rdata0), 32'h866);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
